// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte path.
// States, error codes and bit-level limits.
package usb_rx_pkg;

  localparam int SYNC_BITS     = 8;
  localparam int STUFF_LIMIT   = 6;
  localparam int MAX_BYTES_DEF = 1027;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_SYNC     = 3'd1,
    ERR_STUFF    = 3'd2,
    ERR_ALIGN    = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_SOP      = 3'd5
  } err_t;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Removes stuffed zeros after STUFF_LIMIT consecutive ones.
// A seventh consecutive one is reported as stuff_err.
module usb_bit_unstuffer
  import usb_rx_pkg::*;
(
  input  logic clk36,
  input  logic reset_n,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_valid,
  output logic data_bit,
  output logic data_valid,
  output logic stuff_err
);

  logic [2:0] ones_q;
  logic       at_limit;

  assign at_limit   = (ones_q == 3'(STUFF_LIMIT));
  assign data_bit   = bit_in;
  assign data_valid = bit_valid & ~at_limit;
  assign stuff_err  = bit_valid & at_limit & bit_in;

  // clear preloads 1: the final SYNC one starts the run
  always_ff @(posedge clk36 or negedge reset_n) begin
    if (!reset_n) begin
      ones_q <= '0;
    end else if (clear) begin
      ones_q <= 3'd1;
    end else if (bit_valid) begin
      if (!bit_in)
        ones_q <= '0;
      else if (!at_limit)
        ones_q <= ones_q + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// SYNC check, bit unstuffing and LSB-first byte assembly
// for the full-speed receive path, with packet framing.
module usb_rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic       clk36,
  input  logic       reset_n,
  input  logic       bit_out,
  input  logic       bit_valid,
  input  logic       bus_sop,
  input  logic       bus_eop,
  input  logic       bus_reset,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_first,
  output logic       pkt_active,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic [2:0] err_code
);

  localparam int SCW = $clog2(SYNC_BITS + 1);
  localparam int BCW = $clog2(MAX_BYTES + 2);

  state_t         state, state_d;
  logic [SCW-1:0] sync_cnt, sync_cnt_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [BCW-1:0] byte_cnt, byte_cnt_d;
  logic [7:0]     shift, shift_d;
  logic [7:0]     byte_data_d;
  logic           byte_valid_d, byte_first_d;
  logic           active_d, end_d, err_d;
  err_t           code_q, code_d;

  logic bit_in, sync_last, sync_bad, sync_done;
  logic d_bit, d_valid, stuff_err;
  logic byte_done, overflow;

  // control strobes and bus reset take priority over a bit
  assign bit_in = bit_valid & ~bus_sop & ~bus_eop & ~bus_reset;

  assign sync_last = (sync_cnt == SCW'(SYNC_BITS - 1));
  assign sync_bad  = sync_last ? ~bit_out : bit_out;
  assign sync_done = (state == ST_SYNC) & bit_in
                   & sync_last & bit_out;

  assign byte_done = d_valid & (bit_idx == 3'd7);
  assign overflow  = byte_done
                   & (byte_cnt == BCW'(MAX_BYTES));

  usb_bit_unstuffer u_unstuff (
    .clk36      (clk36),
    .reset_n    (reset_n),
    .clear      (sync_done),
    .bit_in     (bit_out),
    .bit_valid  (bit_in & (state == ST_DATA)),
    .data_bit   (d_bit),
    .data_valid (d_valid),
    .stuff_err  (stuff_err)
  );

  always_ff @(posedge clk36 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sync_cnt   <= '0;
      bit_idx    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_first <= 1'b0;
      pkt_active <= 1'b0;
      pkt_end    <= 1'b0;
      pkt_err    <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state      <= state_d;
      sync_cnt   <= sync_cnt_d;
      bit_idx    <= bit_idx_d;
      byte_cnt   <= byte_cnt_d;
      shift      <= shift_d;
      byte_data  <= byte_data_d;
      byte_valid <= byte_valid_d;
      byte_first <= byte_first_d;
      pkt_active <= active_d;
      pkt_end    <= end_d;
      pkt_err    <= err_d;
      code_q     <= code_d;
    end
  end

  assign err_code = code_q;

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (bus_sop) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (bus_eop)
          state_d = ST_IDLE;
        else if (bus_sop)
          state_d = ST_SYNC;
        else if (bit_in && sync_bad)
          state_d = ST_DROP;
        else if (bit_in && sync_last)
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus_sop)
          state_d = ST_SYNC;
        else if (bus_eop)
          state_d = ST_IDLE;
        else if (stuff_err || overflow)
          state_d = ST_DROP;
      end
      ST_DROP: begin
        if (bus_eop)
          state_d = ST_IDLE;
        else if (bus_sop)
          state_d = ST_SYNC;
      end
    endcase
    if (bus_reset) state_d = ST_IDLE;
  end

  always_comb begin
    sync_cnt_d   = sync_cnt;
    bit_idx_d    = bit_idx;
    byte_cnt_d   = byte_cnt;
    shift_d      = shift;
    byte_data_d  = '0;
    byte_valid_d = 1'b0;
    byte_first_d = 1'b0;
    active_d     = pkt_active;
    end_d        = 1'b0;
    err_d        = 1'b0;
    code_d       = code_q;
    unique case (state)
      ST_IDLE, ST_DROP: begin
        if (bus_sop) sync_cnt_d = '0;
      end
      ST_SYNC: begin
        if (bus_sop) begin
          sync_cnt_d = '0;
        end else if (bit_in) begin
          sync_cnt_d = sync_cnt + SCW'(1);
          if (sync_bad) begin
            code_d = ERR_SYNC;
          end else if (sync_last) begin
            active_d   = 1'b1;
            code_d     = ERR_NONE;
            bit_idx_d  = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
          end
        end
      end
      ST_DATA: begin
        if (bus_sop) begin
          end_d      = 1'b1;
          err_d      = 1'b1;
          code_d     = ERR_SOP;
          active_d   = 1'b0;
          sync_cnt_d = '0;
        end else if (bus_eop) begin
          end_d    = 1'b1;
          active_d = 1'b0;
          if (bit_idx != 3'd0 || byte_cnt == '0) begin
            err_d  = 1'b1;
            code_d = ERR_ALIGN;
          end
        end else if (stuff_err) begin
          end_d    = 1'b1;
          err_d    = 1'b1;
          code_d   = ERR_STUFF;
          active_d = 1'b0;
        end else if (d_valid) begin
          shift_d   = {d_bit, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (overflow) begin
            end_d    = 1'b1;
            err_d    = 1'b1;
            code_d   = ERR_OVERFLOW;
            active_d = 1'b0;
          end else if (byte_done) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_d;
            byte_first_d = (byte_cnt == '0);
            byte_cnt_d   = byte_cnt + BCW'(1);
          end
        end
      end
    endcase
    if (bus_reset) begin
      sync_cnt_d   = '0;
      byte_data_d  = '0;
      byte_valid_d = 1'b0;
      byte_first_d = 1'b0;
      active_d     = 1'b0;
      end_d        = 1'b0;
      err_d        = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Directed bench for usb_rx_byte_assembler; a second
// instance with MAX_BYTES=4 exercises packet overflow.
module tb_usb_rx_byte_assembler;

  logic clk36 = 1'b0;
  logic reset_n, bit_out, bit_valid;
  logic bus_sop, bus_eop, bus_reset;

  logic [7:0] byte_data, byte_data2;
  logic byte_valid, byte_first, pkt_active;
  logic pkt_end, pkt_err;
  logic [2:0] err_code, err_code2;
  logic byte_valid2, byte_first2, pkt_active2;
  logic pkt_end2, pkt_err2;

  int errors = 0;
  int checks = 0;

  int nbytes, nfirst, nend, nbytes2, nend2;
  logic [7:0] last_byte;
  logic last_err, last_err2, act_seen;
  logic [2:0] last_code, last_code2;

  always #14 clk36 = ~clk36;

  usb_rx_byte_assembler dut (
    .clk36      (clk36),
    .reset_n    (reset_n),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bus_sop    (bus_sop),
    .bus_eop    (bus_eop),
    .bus_reset  (bus_reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_first (byte_first),
    .pkt_active (pkt_active),
    .pkt_end    (pkt_end),
    .pkt_err    (pkt_err),
    .err_code   (err_code)
  );

  usb_rx_byte_assembler #(.MAX_BYTES(4)) dut4 (
    .clk36      (clk36),
    .reset_n    (reset_n),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bus_sop    (bus_sop),
    .bus_eop    (bus_eop),
    .bus_reset  (bus_reset),
    .byte_data  (byte_data2),
    .byte_valid (byte_valid2),
    .byte_first (byte_first2),
    .pkt_active (pkt_active2),
    .pkt_end    (pkt_end2),
    .pkt_err    (pkt_err2),
    .err_code   (err_code2)
  );

  always @(negedge clk36) begin
    if (byte_valid) begin
      nbytes++;
      last_byte = byte_data;
      if (byte_first) nfirst++;
    end
    if (pkt_end) begin
      nend++;
      last_err  = pkt_err;
      last_code = err_code;
    end
    if (pkt_active) act_seen = 1'b1;
    if (byte_valid2) nbytes2++;
    if (pkt_end2) begin
      nend2++;
      last_err2  = pkt_err2;
      last_code2 = err_code2;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    nbytes = 0; nfirst = 0; nend = 0;
    nbytes2 = 0; nend2 = 0;
    last_byte = '0; last_err = 1'b0;
    last_code = '0; act_seen = 1'b0;
    last_err2 = 1'b0; last_code2 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk36);
  endtask

  task automatic send_bit(input logic b);
    bit_out = b;
    bit_valid = 1'b1;
    @(negedge clk36);
    bit_valid = 1'b0;
  endtask

  task automatic sop();
    bus_sop = 1'b1;
    @(negedge clk36);
    bus_sop = 1'b0;
  endtask

  task automatic eop();
    bus_eop = 1'b1;
    @(negedge clk36);
    bus_eop = 1'b0;
  endtask

  task automatic sync_bits();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {byte_data, byte_valid, byte_first,
              pkt_active, pkt_end, pkt_err}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; bit_out = 1'b0; bit_valid = 1'b0;
    bus_sop = 1'b0; bus_eop = 1'b0; bus_reset = 1'b0;
    clr();
    idle(3);
    chk_zero("reset_outs");
    chk("reset_code", err_code, 3'd0);
    reset_n = 1'b1;
    idle(2);

    // PID 0x69 clean packet
    clr();
    sop(); sync_bits(); send_byte(8'h69); idle(1);
    eop(); idle(3);
    chk("pid_nbytes", nbytes, 1);
    chk("pid_data", last_byte, 8'h69);
    chk("pid_first", nfirst, 1);
    chk("pid_active", act_seen, 1'b1);
    chk("pid_end", nend, 1);
    chk("pid_err", last_err, 1'b0);
    chk("pid_code", last_code, 3'd0);
    chk("pid_act_off", pkt_active, 1'b0);

    // 0xFF with stuffed zero after 6 ones
    clr();
    sop(); sync_bits();
    repeat (5) send_bit(1'b1);
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    idle(1); eop(); idle(3);
    chk("stuff_nbytes", nbytes, 1);
    chk("stuff_data", last_byte, 8'hFF);
    chk("stuff_err", last_err, 1'b0);

    // seventh consecutive one
    clr();
    sop(); sync_bits();
    repeat (6) send_bit(1'b1);
    idle(2);
    chk("s7_end", nend, 1);
    chk("s7_err", last_err, 1'b1);
    chk("s7_code", err_code, 3'd2);
    send_byte(8'h00); send_byte(8'h5A);
    eop(); idle(3);
    chk("s7_nbytes", nbytes, 0);
    chk("s7_no_end", nend, 1);

    // byte plus 3 dribble bits
    clr();
    sop(); sync_bits(); send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    eop(); idle(3);
    chk("al_nbytes", nbytes, 1);
    chk("al_data", last_byte, 8'hA5);
    chk("al_err", last_err, 1'b1);
    chk("al_code", last_code, 3'd3);

    // SYNC with bit 3 set
    clr();
    sop();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'h69);
    eop(); idle(3);
    chk("sy_code", err_code, 3'd1);
    chk("sy_active", act_seen, 1'b0);
    chk("sy_end", nend, 0);
    chk("sy_nbytes", nbytes, 0);

    // async reset mid-DATA
    clr();
    sop(); sync_bits();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset_n = 1'b0;
    @(negedge clk36);
    chk_zero("rst_mid_outs");
    reset_n = 1'b1;
    idle(2);
    clr();
    sop(); sync_bits(); send_byte(8'h2D); idle(1);
    eop(); idle(3);
    chk("rst_post_data", last_byte, 8'h2D);
    chk("rst_post_n", nbytes, 1);
    chk("rst_post_err", {nend[3:0], last_err}, 5'b00010);

    // bus_reset mid-DATA, with an sop it must ignore
    clr();
    sop(); sync_bits(); send_byte(8'h12);
    send_bit(1'b1); send_bit(1'b1);
    bus_reset = 1'b1;
    @(negedge clk36);
    chk_zero("br_outs");
    idle(4);
    bus_sop = 1'b1;
    @(negedge clk36);
    bus_sop = 1'b0;
    idle(4);
    bus_reset = 1'b0;
    send_byte(8'hFF);
    idle(2);
    chk("br_active", pkt_active, 1'b0);
    chk("br_end", nend, 0);
    chk("br_nbytes", nbytes, 1);
    clr();
    sop(); sync_bits(); send_byte(8'hC3); idle(1);
    eop(); idle(3);
    chk("br_post_data", last_byte, 8'hC3);
    chk("br_post_err", {nend[3:0], last_err}, 5'b00010);

    // sop during DATA aborts and restarts
    clr();
    sop(); sync_bits();
    send_bit(1'b0); send_bit(1'b1);
    sop();
    idle(1);
    chk("sa_end", nend, 1);
    chk("sa_err", last_err, 1'b1);
    chk("sa_code", last_code, 3'd5);
    sync_bits(); send_byte(8'h96); idle(1);
    eop(); idle(3);
    chk("sa_data", last_byte, 8'h96);
    chk("sa_ok", {nend[3:0], last_err}, 5'b00100);
    chk("sa_first", nfirst, 1);

    // 5 bytes: fine for default, overflow for MAX_BYTES=4
    clr();
    sop(); sync_bits();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    idle(2);
    chk("ov_n4", nbytes2, 4);
    chk("ov_end4", nend2, 1);
    chk("ov_err4", last_err2, 1'b1);
    chk("ov_code4", last_code2, 3'd4);
    eop(); idle(3);
    chk("ov_end4_hold", nend2, 1);
    chk("ov_n", nbytes, 5);
    chk("ov_data", last_byte, 8'h55);
    chk("ov_err", {nend[3:0], last_err}, 5'b00010);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
